isqrt_reconstruct: RTL and testbench

- Sequential inverse of the digit-by-digit integer square-root unit.
- Takes a (root, remainder) pair and rebuilds the radicand as root*root + remainder, using an MSB-first shift-add squarer.
- Serves as the self-check and decode path for square-root results on the same tile.
- Uses a valid/ready handshake on both sides.
- Flags any pair whose remainder is non-canonical.

---
 rtl/isqrt_reconstruct.sv | 175 +++++++++++++++++
 tb/tb_isqrt_reconstruct.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_reconstruct.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_reconstruct
//  Description : Sequential inverse of the digit-by-digit integer square root.
//                Accepts a (root, remainder) pair over a valid/ready handshake
//                and rebuilds the radicand as root*root + remainder using an
//                MSB-first shift-add squarer, one root bit per cycle. A pair
//                whose remainder exceeds 2*root is non-canonical and is
//                flagged on err_out.
//
//  Ports       : clk           clock, all state changes on the rising edge
//                rst           synchronous active-high reset
//                in_valid      root_in / rem_in valid
//                in_ready      block can accept a pair (registered)
//                root_in       integer root, ROOT_W bits
//                rem_in        remainder, ROOT_W+1 bits
//                out_valid     radicand_out / err_out valid (registered)
//                out_ready     consumer accepts the result
//                radicand_out  root*root + remainder, mod 2^(2*ROOT_W)
//                err_out       remainder > 2*root (non-canonical pair)
//
//  Revision    : 1.0  initial release
// ============================================================================
module isqrt_reconstruct #(
    parameter int ROOT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROOT_W-1:0]     root_in,
    input  logic [ROOT_W:0]       rem_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*ROOT_W-1:0]   radicand_out,
    output logic                  err_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_RAD_W = 2 * ROOT_W;
    // A single-bit root still needs a 1-bit counter to stay well formed.
    localparam int c_CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(ROOT_W - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [c_RAD_W-1:0]  r_radicand;
    logic                r_err;

    logic [ROOT_W-1:0]   r_root;     // captured root, multiplicand and multiplier
    logic [ROOT_W:0]     r_rem;      // captured remainder, added on the last step
    logic                r_err_q;    // canonicity verdict taken at capture
    logic [c_RAD_W-1:0]  r_acc;      // partial product of root*root
    logic [c_CNT_W-1:0]  r_count;    // index of the root bit being consumed

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic                w_err_in;
    logic [c_CNT_W-1:0]  w_bit_idx;
    logic                w_bit;
    logic [c_RAD_W-1:0]  w_addend;
    logic [c_RAD_W-1:0]  w_acc_next;
    logic [c_RAD_W-1:0]  w_sum;
    logic                w_last;

    // Canonical remainders satisfy rem <= 2*root; both sides are ROOT_W+1 bits
    // so 2*root cannot overflow the comparison.
    assign w_err_in   = (rem_in > {root_in, 1'b0});

    // Multiplier bits are consumed MSB first: count 0 selects bit ROOT_W-1.
    assign w_bit_idx  = c_LAST_CNT - r_count;
    assign w_bit      = r_root[w_bit_idx];

    // Horner form of root*root: acc = 2*acc + bit*root, one bit per cycle.
    assign w_addend   = w_bit ? c_RAD_W'(r_root) : '0;
    assign w_acc_next = (r_acc << 1) + w_addend;

    // Final radicand; wraps mod 2^RAD_W, which can only happen for
    // non-canonical pairs since (2^n-1)^2 + 2(2^n-1) = 2^2n - 1.
    assign w_sum      = w_acc_next + c_RAD_W'(r_rem);

    assign w_last     = (r_count == c_LAST_CNT);

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_radicand  <= '0;
            r_err       <= 1'b0;
            r_root      <= '0;
            r_rem       <= '0;
            r_err_q     <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_root     <= root_in;
                        r_rem      <= rem_in;
                        r_err_q    <= w_err_in;
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_ST_RUN;
                    end
                end

                c_ST_RUN: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        // Counter is left at its final value rather than
                        // wrapping; the next capture clears it.
                        r_radicand  <= w_sum;
                        r_err       <= r_err_q;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                c_ST_DONE: begin
                    // Result registers are only rewritten on the next
                    // completion, so they stay stable under backpressure.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end

                default: begin
                    // Unreachable encoding: recover exactly as from reset.
                    r_state     <= c_ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_radicand  <= '0;
                    r_err       <= 1'b0;
                    r_root      <= '0;
                    r_rem       <= '0;
                    r_err_q     <= 1'b0;
                    r_acc       <= '0;
                    r_count     <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign radicand_out = r_radicand;
    assign err_out      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_isqrt_reconstruct.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isqrt_reconstruct
//  Description : Self-checking bench for isqrt_reconstruct (ROOT_W = 4).
//                Expected results come from integer arithmetic on the pair
//                (root*root + rem mod 256, rem > 2*root) and from an integer
//                square-root model for the canonical sweep.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_isqrt_reconstruct;

    localparam int c_ROOT_W = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] root_in;
    logic [4:0] rem_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] radicand_out;
    logic       err_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    isqrt_reconstruct #(.ROOT_W(c_ROOT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .root_in      (root_in),
        .rem_in       (rem_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .radicand_out (radicand_out),
        .err_out      (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the pair.
    function automatic logic [7:0] model_rad(input int rt, input int rm);
        return 8'((rt * rt + rm) % 256);
    endfunction

    function automatic logic model_err(input int rt, input int rm);
        return (rm > 2 * rt);
    endfunction

    // Drives one pair through the handshake and collects the result.
    // lat is the number of edges from acceptance to out_valid (20 = timeout).
    task automatic run_pair(input logic [3:0] rt, input logic [4:0] rm,
                            output logic [7:0] rad, output logic er,
                            output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        root_in  = rt;
        rem_in   = rm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        root_in  = 4'($urandom);
        rem_in   = 5'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rad = radicand_out;
        er  = err_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        root_in = '0; rem_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total_cnt++;
        if ({in_ready, out_valid, radicand_out, err_out} !== {1'b1, 1'b0, 8'd0, 1'b0})
            $display("FAIL reset: in_ready=%b out_valid=%b rad=%0d err=%b, expected 1 0 0 0",
                     in_ready, out_valid, radicand_out, err_out);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [7:0] rad; logic er; int lat;
        run_pair(4'd15, 5'd30, rad, er, lat);
        total_cnt++;
        if (lat !== 4) $display("FAIL latency_15_30: got %0d expected 4", lat);
        else pass_cnt++;
        total_cnt++;
        if ({rad, er} !== {8'd255, 1'b0})
            $display("FAIL basic_15_30: rad=%0d err=%b expected 255 0", rad, er);
        else pass_cnt++;

        run_pair(4'd0, 5'd0, rad, er, lat);
        total_cnt++;
        if ({rad, er} !== {8'd0, 1'b0})
            $display("FAIL basic_0_0: rad=%0d err=%b expected 0 0", rad, er);
        else pass_cnt++;

        run_pair(4'd10, 5'd5, rad, er, lat);
        total_cnt++;
        if ({rad, er} !== {8'd105, 1'b0})
            $display("FAIL basic_10_5: rad=%0d err=%b expected 105 0", rad, er);
        else pass_cnt++;
    endtask

    // Every 8-bit radicand decomposed by an integer square root must come back.
    task automatic test_sweep();
        logic [7:0] rad; logic er; int lat;
        int s;
        for (int r = 0; r < 256; r++) begin
            s = 0;
            while ((s + 1) * (s + 1) <= r) s++;
            run_pair(4'(s), 5'(r - s * s), rad, er, lat);
            total_cnt++;
            if (rad !== 8'(r) || er !== 1'b0 || lat !== 4)
                $display("FAIL sweep r=%0d: rad=%0d err=%b lat=%0d expected %0d 0 4",
                         r, rad, er, lat, r);
            else pass_cnt++;
        end
    endtask

    task automatic test_error();
        logic [7:0] rad; logic er; int lat;
        run_pair(4'd3, 5'd7, rad, er, lat);
        total_cnt++;
        if ({rad, er} !== {8'd16, 1'b1})
            $display("FAIL err_3_7: rad=%0d err=%b expected 16 1", rad, er);
        else pass_cnt++;

        run_pair(4'd15, 5'd31, rad, er, lat);
        total_cnt++;
        if ({rad, er} !== {8'd0, 1'b1})
            $display("FAIL err_15_31: rad=%0d err=%b expected 0 1", rad, er);
        else pass_cnt++;

        // Exact boundary: rem == 2*root is canonical.
        run_pair(4'd7, 5'd14, rad, er, lat);
        total_cnt++;
        if ({rad, er} !== {8'd63, 1'b0})
            $display("FAIL err_7_14: rad=%0d err=%b expected 63 0", rad, er);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int w;
        root_in = 4'd9; rem_in = 5'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1; w++;
        end
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({out_valid, radicand_out, err_out, in_ready} !== {1'b1, 8'd83, 1'b0, 1'b0})
                $display("FAIL backpressure cyc %0d: valid=%b rad=%0d err=%b in_ready=%b expected 1 83 0 0",
                         i, out_valid, radicand_out, err_out, in_ready);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL backpressure release: valid=%b in_ready=%b expected 0 1",
                     out_valid, in_ready);
        else pass_cnt++;
    endtask

    // in_valid held high with fresh random data every cycle; only the pair
    // present at each acceptance edge may appear at the output.
    task automatic test_back_to_back();
        logic [8:0] q[$];
        logic [8:0] exp_pair;
        int last_out, n_out, rt, rm;
        last_out = -1; n_out = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            root_in = 4'($urandom);
            rem_in  = 5'($urandom);
            if (in_ready) q.push_back({root_in, rem_in});
            if (i == 25) in_valid = 1'b0;
            @(posedge clk); #1;
            if (out_valid) begin
                n_out++;
                total_cnt++;
                if (q.size() == 0) begin
                    $display("FAIL b2b unexpected result at cyc %0d", i);
                end else begin
                    exp_pair = q.pop_front();
                    rt = int'(exp_pair[8:5]);
                    rm = int'(exp_pair[4:0]);
                    if ({radicand_out, err_out, in_ready} !== {model_rad(rt, rm), model_err(rt, rm), 1'b0})
                        $display("FAIL b2b root=%0d rem=%0d: rad=%0d err=%b in_ready=%b expected %0d %b 0",
                                 rt, rm, radicand_out, err_out, in_ready,
                                 model_rad(rt, rm), model_err(rt, rm));
                    else pass_cnt++;
                end
                if (last_out >= 0) begin
                    total_cnt++;
                    if (i - last_out !== 6)
                        $display("FAIL b2b spacing: got %0d expected 6", i - last_out);
                    else pass_cnt++;
                end
                last_out = i;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total_cnt++;
        if (n_out !== 5 || q.size() !== 0)
            $display("FAIL b2b count: results=%0d pending=%0d expected 5 0", n_out, q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        logic [7:0] rad; logic er; int lat; int seen;
        run_pair(4'd9, 5'd2, rad, er, lat);      // leaves a nonzero result
        root_in = 4'd13; rem_in = 5'd4; in_valid = 1'b1;
        @(posedge clk); #1;                      // accepted, count = 0
        in_valid = 1'b0;
        @(posedge clk); #1;                      // count = 1
        @(posedge clk); #1;                      // count = 2
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if ({in_ready, out_valid, radicand_out, err_out} !== {1'b1, 1'b0, 8'd0, 1'b0})
            $display("FAIL abort state: in_ready=%b valid=%b rad=%0d err=%b expected 1 0 0 0",
                     in_ready, out_valid, radicand_out, err_out);
        else pass_cnt++;
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        total_cnt++;
        if (seen !== 0) $display("FAIL abort no_result: got %0d results expected 0", seen);
        else pass_cnt++;
        run_pair(4'd12, 5'd20, rad, er, lat);
        total_cnt++;
        if ({rad, er, lat} !== {8'd164, 1'b0, 32'd4})
            $display("FAIL abort recovery: rad=%0d err=%b lat=%0d expected 164 0 4", rad, er, lat);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0] rad; logic er; int lat; int rt, rm;
        for (int i = 0; i < 40; i++) begin
            rt = int'($urandom_range(0, 15));
            rm = int'($urandom_range(0, 31));
            run_pair(4'(rt), 5'(rm), rad, er, lat);
            total_cnt++;
            if (rad !== model_rad(rt, rm) || er !== model_err(rt, rm) || lat !== 4)
                $display("FAIL random root=%0d rem=%0d: rad=%0d err=%b lat=%0d expected %0d %b 4",
                         rt, rm, rad, er, lat, model_rad(rt, rm), model_err(rt, rm));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
